// File: rtl/mmio_seg_display_pkg.sv
// mmio_seg_pkg: shared types and constants for the memory-mapped seven-segment display.
// Contents: the scan FSM state type, the CTRL register bit positions and the
//           active-low hex-to-segment table, ordered {g,f,e,d,c,b,a}.
package mmio_seg_pkg;

    typedef enum logic {
        S_ON  = 1'b0,
        S_GAP = 1'b1
    } scan_state_t;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_ZB_BIT    = 1;
    localparam int CTRL_BLINK_BIT = 2;

    // Common-anode digits: a 0 lights the segment.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

endpackage

// File: rtl/mmio_seg_display_if.sv
// mmio_seg_display_if: CPU store-bus snoop signals seen by the display peripheral.
// Signals: mem_write (store strobe), data_adr (32-bit store address), write_data (32-bit store data).
// Modports: master drives the bus (core side), slave only observes it (peripheral side).
interface mmio_seg_display_if;
    logic        mem_write;
    logic [31:0] data_adr;
    logic [31:0] write_data;

    modport master (output mem_write, output data_adr, output write_data);
    modport slave  (input  mem_write, input  data_adr, input  write_data);
endinterface

// File: rtl/mmio_seg_display_hex_to_segments.sv
// hex_to_segments: combinational 4-bit hex to active-low 7-segment decoder.
// Ports: hex (4-bit nibble in), seg (7-bit {g,f,e,d,c,b,a} out, active-low).
// Latency: purely combinational, no state.
module hex_to_segments
    import mmio_seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/mmio_seg_display.sv
// mmio_seg_display: store-snooping VALUE/CTRL registers driving a 4-digit multiplexed
// common-anode display, with a blank gap between digits to prevent ghosting.
// Ports: clk, rst (sync, active-high), bus (store snoop, slave modport), segments/anodes
// (registered, active-low), disp_value/disp_ctrl (register read-back).
// Optional: define DISP_BLINK_EN to build the blink toggle honoured by CTRL bit2.
module mmio_seg_display
    import mmio_seg_pkg::*;
#(
    parameter logic [31:0] DISP_ADDR   = 32'h0000_0400,
    parameter int          REFRESH_DIV = 50000,
    parameter int          GAP_CYCLES  = 16,
    parameter int          BLINK_DIV   = 25000000
) (
    input  logic                 clk,
    input  logic                 rst,
    mmio_seg_display_if.slave    bus,
    output logic [6:0]           segments,
    output logic [3:0]           anodes,
    output logic [15:0]          disp_value,
    output logic [2:0]           disp_ctrl
);

    // Reject configurations whose counters would never reach terminal count.
    if (REFRESH_DIV < 1 || GAP_CYCLES < 1 || BLINK_DIV < 1) begin : g_bad_cfg
        $error("mmio_seg_display: REFRESH_DIV, GAP_CYCLES and BLINK_DIV must be >= 1");
    end

    localparam int MAX_PHASE = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
    localparam int CNT_W     = $clog2(MAX_PHASE + 1);
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    // ---------------------------------------------------------------- registers
    logic hit_value;
    logic hit_ctrl;

    assign hit_value = bus.mem_write && (bus.data_adr == DISP_ADDR);
    assign hit_ctrl  = bus.mem_write && (bus.data_adr == DISP_ADDR + 32'd4);

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_value <= 16'h0000;
            disp_ctrl  <= 3'b001;
        end else if (hit_value) begin
            disp_value <= bus.write_data[15:0];
        end else if (hit_ctrl) begin
            disp_ctrl  <= bus.write_data[2:0];
        end
    end

    // Upper data bits are architecturally ignored.
    logic unused_data_hi;
    assign unused_data_hi = ^bus.write_data[31:16];

    // ---------------------------------------------------------------- scan FSM
    scan_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic             enable;

    assign enable = disp_ctrl[CTRL_EN_BIT];

    // Disabling parks the scan at its reset point so re-enabling starts on digit 0.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            state <= S_ON;
            cnt   <= '0;
            idx   <= 2'd0;
        end else begin
            case (state)
                S_ON: begin
                    if (cnt == ON_LAST) begin
                        state <= S_GAP;
                        cnt   <= '0;
                    end else begin
                        cnt   <= cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        state <= S_ON;
                        cnt   <= '0;
                        idx   <= idx + 2'd1;
                    end else begin
                        cnt   <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_ON;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------- digit select
    logic [3:0] nibble;
    logic [6:0] seg_dec;
    logic       digit_blank;

    assign nibble = disp_value[{idx, 2'b00} +: 4];

    hex_to_segments u_dec (
        .hex (nibble),
        .seg (seg_dec)
    );

    // Leading-zero suppression: a digit goes dark when it and every digit to its
    // left are zero; the rightmost digit always shows.
    always_comb begin
        digit_blank = 1'b0;
        if (disp_ctrl[CTRL_ZB_BIT]) begin
            case (idx)
                2'd1:    digit_blank = (disp_value[15:4]  == 12'h000);
                2'd2:    digit_blank = (disp_value[15:8]  == 8'h00);
                2'd3:    digit_blank = (disp_value[15:12] == 4'h0);
                default: digit_blank = 1'b0;
            endcase
        end
    end

    // ---------------------------------------------------------------- blink
    logic blink_off;

`ifdef DISP_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_DIV + 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;

    // Free-running: the scan keeps its position while the display is blinked off.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end

    assign blink_off = disp_ctrl[CTRL_BLINK_BIT] & blink_phase;
`else
    assign blink_off = 1'b0;
`endif

    // ---------------------------------------------------------------- outputs
    // Registered from the current FSM state, so the pins trail the FSM by one cycle.
    // Segments are left untouched outside S_ON to avoid glitching while anodes are off.
    always_ff @(posedge clk) begin
        if (rst) begin
            anodes   <= 4'b1111;
            segments <= 7'h7F;
        end else if (!enable) begin
            anodes   <= 4'b1111;
        end else if (state == S_ON) begin
            segments <= seg_dec;
            anodes   <= (digit_blank || blink_off) ? 4'b1111 : ~(4'b0001 << idx);
        end else begin
            anodes   <= 4'b1111;
        end
    end

endmodule

// File: tb/tb_mmio_seg_display.sv
// tb_mmio_seg_display: directed plus randomized bench for mmio_seg_display.
// The reference model tracks the scan as a single position within the 4-digit frame
// and derives the expected pin values arithmetically from that position.
module tb_mmio_seg_display;

    localparam logic [31:0] A = 32'h0000_0400;
    localparam int R = 4;
    localparam int G = 1;
    localparam int B = 8;
    localparam int FRAME = 4 * (R + G);

    logic        clk;
    logic        rst;
    logic [6:0]  segments;
    logic [3:0]  anodes;
    logic [15:0] disp_value;
    logic [2:0]  disp_ctrl;

    mmio_seg_display_if bus ();

    mmio_seg_display #(
        .DISP_ADDR   (A),
        .REFRESH_DIV (R),
        .GAP_CYCLES  (G),
        .BLINK_DIV   (B)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .segments   (segments),
        .anodes     (anodes),
        .disp_value (disp_value),
        .disp_ctrl  (disp_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent copy of the digit shapes, active-low {g,f,e,d,c,b,a}.
    logic [6:0] seg_ref [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int checks = 0;
    int errors = 0;

    // Model state
    logic [15:0] m_val  = 16'h0000;
    logic [2:0]  m_ctrl = 3'b001;
    int          pos    = 0;   // cycles into the scan frame since (re)start
    int          cyc    = 0;   // cycles since reset release
    logic [3:0]  exp_an  = 4'b1111;
    logic [6:0]  exp_seg = 7'h7F;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step(input bit r, input bit we, input logic [31:0] a, input logic [31:0] d);
        int         dig;
        int         slot;
        logic [2:0] c_old;
        rst            = r;
        bus.mem_write  = we;
        bus.data_adr   = a;
        bus.write_data = d;
        @(posedge clk);
        if (r) begin
            m_val   = 16'h0000;
            m_ctrl  = 3'b001;
            pos     = 0;
            cyc     = 0;
            exp_an  = 4'b1111;
            exp_seg = 7'h7F;
        end else begin
            c_old = m_ctrl;
            if (!m_ctrl[0]) begin
                exp_an = 4'b1111;
            end else begin
                slot = pos % (R + G);
                dig  = pos / (R + G);
                if (slot < R) begin
                    exp_seg = seg_ref[(m_val >> (4 * dig)) & 16'hF];
                    exp_an  = ~(4'b0001 << dig);
                    if (m_ctrl[1] && dig > 0 && (m_val >> (4 * dig)) == 16'h0)
                        exp_an = 4'b1111;
`ifdef DISP_BLINK_EN
                    if (m_ctrl[2] && ((cyc / B) % 2 == 1))
                        exp_an = 4'b1111;
`endif
                end else begin
                    exp_an = 4'b1111;
                end
            end
            if (we && a == A)
                m_val = d[15:0];
            else if (we && a == A + 32'd4)
                m_ctrl = d[2:0];
            pos = c_old[0] ? (pos + 1) % FRAME : 0;
            cyc++;
        end
        #1;
        chk("anodes",     {12'h0, anodes},    {12'h0, exp_an});
        chk("segments",   {9'h0, segments},   {9'h0, exp_seg});
        chk("disp_value", disp_value,         m_val);
        chk("disp_ctrl",  {13'h0, disp_ctrl}, {13'h0, m_ctrl});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        step(1'b0, 1'b1, a, d);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] a;
        rst = 1'b1;
        bus.mem_write  = 1'b0;
        bus.data_adr   = 32'h0;
        bus.write_data = 32'h0;

        // Reset held two cycles, then the first digit lights showing "0".
        step(1'b1, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b1, A, 32'hFFFF_FFFF);   // bus ignored during reset
        idle(1);
        chk("first_digit_an",  {12'h0, anodes},   16'h000E);
        chk("first_digit_seg", {9'h0, segments},  16'h0040);

        // Full scan of 1234
        wr(A, 32'hFFFF_1234);
        chk("value_1234", disp_value, 16'h1234);
        idle(22);

        // Non-matching address and unasserted strobe are ignored
        wr(A + 32'd8, 32'h0000_BEEF);
        step(1'b0, 1'b0, A, 32'h0000_5A5A);
        chk("value_kept", disp_value, 16'h1234);
        idle(3);

        // Zero blanking on 0005
        wr(A, 32'h0000_0005);
        wr(A + 32'd4, 32'h0000_0003);
        idle(24);

        // Disable during digit 2 ON, then re-enable
        wr(A + 32'd4, 32'h0000_0001);
        wr(A, 32'h0000_ABCD);
        for (int k = 0; k < 2 * FRAME && !((pos / (R + G)) == 2 && (pos % (R + G)) == 1); k++)
            idle(1);
        wr(A + 32'd4, 32'h0000_0000);
        idle(1);
        chk("disabled_an", {12'h0, anodes}, 16'h000F);
        idle(5);
        wr(A + 32'd4, 32'h0000_0001);
        idle(1);
        chk("restart_an", {12'h0, anodes}, 16'h000E);
        idle(8);

        // Blink request: effective only when the feature is built
        wr(A + 32'd4, 32'h0000_0005);
        idle(40);

        // Randomized bus traffic including occasional resets
        for (int k = 0; k < 600; k++) begin
            d = $urandom;
            if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
            case ($urandom_range(0, 3))
                0:       a = A;
                1:       a = A + 32'd4;
                2:       a = A + 32'd8;
                default: a = $urandom;
            endcase
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0), a, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_seg_display.md
Name: mmio_seg_display

Overview:
- Memory-mapped display peripheral on the CPU store bus, directly downstream of the core wrapper.
- Snoops every store (mem_write, data_adr, write_data) and latches stores that hit its two registers.
- Time-multiplexes a 16-bit value onto four common-anode seven-segment digits.
- Inserts a blanking gap between digits to prevent ghosting.

Parameters:
- DISP_ADDR, 32'h0000_0400, word address of the VALUE register. CTRL register is at DISP_ADDR+4.
- REFRESH_DIV, 50000, clock cycles each digit stays lit (ON phase), >=1.
- GAP_CYCLES, 16, clock cycles all anodes are off between digits, >=1.
- BLINK_DIV, 25000000, half-period in cycles of the blink toggle (used only with DISP_BLINK_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_write  in  1  store strobe from the core.
- data_adr  in  32  store address.
- write_data  in  32  store data.
- segments  out  7  active-low {g,f,e,d,c,b,a}, registered.
- anodes  out  4  active-low digit enables, bit0 = rightmost digit, registered.
- disp_value  out  16  current VALUE register contents.
- disp_ctrl  out  3  current CTRL register contents.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values:
  - VALUE = 16'h0000.
  - CTRL = 3'b001 (bit0 enable=1, bit1 zero-blank=0, bit2 blink=0).
  - State = S_ON, digit index = 0, phase counter = 0.
  - anodes = 4'b1111, segments = 7'h7F.
- Register writes:
  - mem_write=1 and data_adr==DISP_ADDR: VALUE <= write_data[15:0].
  - mem_write=1 and data_adr==DISP_ADDR+4: CTRL <= write_data[2:0].
  - Full 32-bit address compare. All other addresses and upper data bits are ignored.
  - disp_value/disp_ctrl update on the same edge as the write.
- Scan FSM, states S_ON and S_GAP:
  - S_ON: counter counts 0..REFRESH_DIV-1. At terminal count go to S_GAP and clear the counter.
  - S_GAP: counter counts 0..GAP_CYCLES-1. At terminal count go to S_ON, clear the counter, and advance the digit index modulo 4 (3 wraps to 0).
- Enable=0:
  - FSM, counter and digit index are held at their reset values.
  - anodes = 4'b1111.
  - When enable returns to 1, scanning restarts at digit 0, S_ON, count 0.
- Output registration:
  - anodes and segments are registered from the current state, index and VALUE, so they lag the FSM by 1 cycle.
  - In S_ON: anodes = ~(1<<index); segments = decode(VALUE[4*index+3 : 4*index]).
  - In S_GAP: anodes = 4'b1111; segments hold their previous value.
- Write latency: a VALUE write made during S_ON is visible on segments 1 cycle after the write edge. No scan restart.
- Zero blanking (CTRL bit1=1):
  - Digit i>0 is blanked (anode off) when VALUE bits [15 : 4*i] are all zero.
  - Digit 0 is never blanked, so VALUE=0 shows a single "0".
- rst during any phase returns everything to reset values on that edge; the write-capture logic ignores the bus in a reset cycle.

Optional Feature:
- Macro: DISP_BLINK_EN.
- Defined:
  - A free-running counter toggles blink_phase every BLINK_DIV cycles; reset values are counter 0, blink_phase 0.
  - When CTRL bit2=1 and blink_phase=1, anodes are forced to 4'b1111. The FSM keeps running.
- Undefined:
  - No blink logic is built.
  - CTRL bit2 is still stored and read back on disp_ctrl, but has no effect.

Decomposition:
- Package mmio_seg_pkg holds:
  - enum scan_state_t {S_ON, S_GAP};
  - localparam CTRL_EN_BIT=0, CTRL_ZB_BIT=1, CTRL_BLINK_BIT=2;
  - the 16-entry hex-to-segment constant table, active-low.
- One sub-module, hex_to_segments: combinational 4-bit to 7-bit decoder using the package table.
- FSM, counters, registers and blanking stay in mmio_seg_display.

Test Plan:
- Test parameters: REFRESH_DIV=4, GAP_CYCLES=1, BLINK_DIV=8.
- Reset: hold rst 2 cycles, then release -> anodes=4'b1111 during reset; next cycle anodes=4'b1110 and segments=7'h40 ("0"); disp_ctrl=3'b001.
- Write 32'hFFFF_1234 to DISP_ADDR -> disp_value=16'h1234. Over 20 cycles the anodes sequence is 1110(x4), 1111(x1), 1101(x4), 1111, 1011, ..., 0111, then wraps to 1110. Segments are 7'h19 ("4") on digit 0 and 7'h79 ("1") on digit 3.
- Write to DISP_ADDR+8 and to DISP_ADDR with mem_write=0 -> disp_value unchanged.
- Write VALUE=16'h0005 and CTRL=3'b011 -> only anodes 1110 are ever asserted; the digits 1-3 slots show 1111; segments=7'h12.
- Write CTRL=3'b000 mid-S_ON of digit 2 -> next cycle anodes=1111 and held. Then write CTRL=3'b001 -> scanning resumes at digit 0 (anodes 1110).
- With DISP_BLINK_EN and CTRL=3'b101 -> anodes are all 1111 for 8-cycle windows alternating with normal scan; without the macro the same CTRL value gives normal scan.
